// File: rtl/nvz_flag_reg_if.sv
// rtl/nvz_flag_reg_if.sv - execute-stage flag bus between pipeline and the NVZ flag register
//
// Purpose: bundles the execute-stage result, pipeline control, trap save/restore
// controls and the flag outputs of nvz_flag_reg.
// Ports (signals):
//   opcode[3:0], alu_out[15:0], alu_ovfl, ex_valid   execute-stage instruction
//   stall, flush                                      pipeline control
//   save, restore                                     shadow register control
//   NVZ[2:0], NVZ_fwd[2:0], shadow_valid              flag outputs
// Modports: master (pipeline side), slave (flag register side).
interface nvz_flag_reg_if;
  logic [3:0]  opcode;
  logic [15:0] alu_out;
  logic        alu_ovfl;
  logic        ex_valid;
  logic        stall;
  logic        flush;
  logic        save;
  logic        restore;
  logic [2:0]  NVZ;
  logic [2:0]  NVZ_fwd;
  logic        shadow_valid;

  modport master (
    output opcode, alu_out, alu_ovfl, ex_valid, stall, flush, save, restore,
    input  NVZ, NVZ_fwd, shadow_valid
  );

  modport slave (
    input  opcode, alu_out, alu_ovfl, ex_valid, stall, flush, save, restore,
    output NVZ, NVZ_fwd, shadow_valid
  );
endinterface

// File: rtl/nvz_flag_reg.sv
// rtl/nvz_flag_reg.sv - {N,V,Z} condition flag register with single-level shadow
//
// Purpose: holds the N/V/Z flags written by the execute stage, with a one-deep
// shadow copy for trap entry/return.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset
//   bus   slave modport of nvz_flag_reg_if (execute inputs, control, flag outputs)
// Optional feature: define NVZ_FLAG_BYPASS_EN to forward next-state flags on
// NVZ_fwd in the same cycle; otherwise NVZ_fwd mirrors NVZ.
module nvz_flag_reg (
  input  logic            clk,
  input  logic            rst,
  nvz_flag_reg_if.slave   bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  typedef enum logic {IDLE = 1'b0, SAVED = 1'b1} state_t;

  state_t     state_q, state_next;
  logic [2:0] nvz_q, nvz_next;
  logic [2:0] shadow_q, shadow_next;
  logic [2:0] upd_nvz;
  logic       full_class;
  logic       z_class;
  logic       update_en;
  logic       z_val;

  always_comb begin
    full_class = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB);
    z_class    = (bus.opcode == OP_XOR) || (bus.opcode == OP_SLL) ||
                 (bus.opcode == OP_SRA) || (bus.opcode == OP_ROR);
    update_en  = bus.ex_valid && !bus.stall && !bus.flush && (full_class || z_class);
    z_val      = (bus.alu_out == 16'h0000);
  end

  // upd_nvz is the post-update value of this cycle; save captures it so a trap
  // taken alongside a flag writer preserves that writer's result.
  always_comb begin
    upd_nvz     = nvz_q;
    nvz_next    = nvz_q;
    shadow_next = shadow_q;
    state_next  = state_q;

    if (update_en) begin
      if (full_class) begin
        upd_nvz = {bus.alu_out[15], bus.alu_ovfl, z_val};
      end else begin
        upd_nvz[0] = z_val;
      end
    end

    if (bus.restore) begin
      // Restore wins over everything; with nothing saved the flags are left alone.
      state_next = IDLE;
      if (state_q == SAVED) begin
        nvz_next = shadow_q;
      end
    end else begin
      nvz_next = upd_nvz;
      if (bus.save) begin
        shadow_next = upd_nvz;
        state_next  = SAVED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      nvz_q    <= 3'b000;
      shadow_q <= 3'b000;
    end else begin
      state_q  <= state_next;
      nvz_q    <= nvz_next;
      shadow_q <= shadow_next;
    end
  end

  assign bus.NVZ          = nvz_q;
  assign bus.shadow_valid = (state_q == SAVED);

`ifdef NVZ_FLAG_BYPASS_EN
  // nvz_next already equals nvz_q when no update or restore is pending.
  assign bus.NVZ_fwd = nvz_next;
`else
  assign bus.NVZ_fwd = nvz_q;
`endif

endmodule

// File: tb/tb_nvz_flag_reg.sv
// tb/tb_nvz_flag_reg.sv - directed self-checking bench for nvz_flag_reg
module tb_nvz_flag_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  nvz_flag_reg_if bus ();

  nvz_flag_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks NVZ and shadow_valid; NVZ_fwd must track NVZ when no update is pending.
  task automatic chk_state(input string tag, input logic [2:0] exp_nvz, input logic exp_sv);
    chk({tag, "_nvz"}, bus.NVZ, exp_nvz);
    chk({tag, "_sv"}, {2'b00, bus.shadow_valid}, {2'b00, exp_sv});
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] alu, input logic ov,
                       input logic ev, input logic st, input logic fl,
                       input logic sv, input logic rs);
    bus.opcode   = op;
    bus.alu_out  = alu;
    bus.alu_ovfl = ov;
    bus.ex_valid = ev;
    bus.stall    = st;
    bus.flush    = fl;
    bus.save     = sv;
    bus.restore  = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(4'b1111, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    idle();
    #2;
    chk_state("reset", 3'b000, 1'b0);
    chk("reset_fwd", bus.NVZ_fwd, 3'b000);
    tick();
    rst = 1'b0;

    // SUB zero result -> Z only
    drive(4'b0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("sub_zero", 3'b001, 1'b0);

    // ADD negative with overflow
    drive(4'b0000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("add_neg_ovf", 3'b110, 1'b0);

    // XOR zero: Z set, N,V retained
    drive(4'b0010, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("xor_zero", 3'b111, 1'b0);

    // opcode 0011 updates nothing
    drive(4'b0011, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("op0011", 3'b111, 1'b0);
    chk("fwd_idle", bus.NVZ_fwd, 3'b111);

    // Asynchronous reset mid-cycle, with a writer in flight
    drive(4'b0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 3'b000, 1'b0);
    tick();
    chk_state("rst_held", 3'b000, 1'b0);
    idle();
    rst = 1'b0;
    tick();
    chk_state("post_rst", 3'b000, 1'b0);

    // SUB zero suppressed by stall, flush, ex_valid=0
    drive(4'b0001, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("stall_hold", 3'b000, 1'b0);
    drive(4'b0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_state("flush_hold", 3'b000, 1'b0);
    drive(4'b0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("bubble_hold", 3'b000, 1'b0);

    // NVZ=100, save, ADD -> 001, restore -> 100
    drive(4'b0000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("add_100", 3'b100, 1'b0);
    idle();
    bus.save = 1'b1;
    tick();
    chk_state("save", 3'b100, 1'b1);
    drive(4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("add_001", 3'b001, 1'b1);
    idle();
    bus.restore = 1'b1;
    tick();
    chk_state("restore", 3'b100, 1'b0);

    // Save captures post-update flags of the same cycle
    drive(4'b0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("save_with_add", 3'b000, 1'b1);

    // ADD 0xFFFF: forwarding check before the edge
    drive(4'b0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef NVZ_FLAG_BYPASS_EN
    chk("fwd_same_cycle", bus.NVZ_fwd, 3'b100);
`else
    chk("fwd_same_cycle", bus.NVZ_fwd, 3'b000);
`endif
    tick();
    chk_state("add_ffff", 3'b100, 1'b1);

    // Restore beats flush and ADD in the same cycle
    drive(4'b0000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
`ifdef NVZ_FLAG_BYPASS_EN
    chk("fwd_restore", bus.NVZ_fwd, 3'b000);
`else
    chk("fwd_restore", bus.NVZ_fwd, 3'b100);
`endif
    tick();
    chk_state("restore_prio", 3'b000, 1'b0);

    // Restore with nothing saved leaves NVZ alone
    drive(4'b0000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_state("restore_empty", 3'b000, 1'b0);

    // Save while saved overwrites the shadow
    drive(4'b0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("save1", 3'b100, 1'b1);
    drive(4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("add_001b", 3'b001, 1'b1);
    idle();
    bus.save = 1'b1;
    tick();
    chk_state("save2", 3'b001, 1'b1);
    drive(4'b0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("add_100b", 3'b100, 1'b1);
    idle();
    bus.restore = 1'b1;
    tick();
    chk_state("restore_overwrite", 3'b001, 1'b0);

    // Save together with restore is ignored
    idle();
    bus.save    = 1'b1;
    bus.restore = 1'b1;
    tick();
    chk_state("save_and_restore", 3'b001, 1'b0);

    // Save/restore still act during stall; the stalled writer does not
    drive(4'b0000, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("stall_save", 3'b001, 1'b1);
    drive(4'b0000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("add_110", 3'b110, 1'b1);
    drive(4'b0001, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_state("stall_restore", 3'b001, 1'b0);

    // Z-only shifts: SRA zero sets Z, ROR nonzero clears it
    drive(4'b0000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(4'b0101, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("sra_zero", 3'b111, 1'b0);
    drive(4'b0110, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("ror_nz", 3'b110, 1'b0);
    drive(4'b0100, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("sll_zero", 3'b111, 1'b0);

    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
